id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have port if_valid, input, 1, meaning the IF/ID slot holds a real instruction.
REQ-005 SHALL have port if_pc, input, XLEN, meaning the PC of that instruction.
REQ-006 SHALL have port if_instr, input, 32, meaning the RV32I instruction word.
REQ-007 SHALL have port flush, input, 1, meaning EX redirect (taken branch or jump), which kills the instruction in ID.
REQ-008 SHALL have port id_stall, output, 1, meaning upstream holds PC and IF/ID this cycle.
REQ-009 SHALL have ports ra1 and ra2, output, 5, meaning register-file read addresses.
REQ-010 SHALL have ports rd1 and rd2, input, XLEN, meaning register-file read data (asynchronous read, x0 reads 0).
REQ-011 SHALL have ports wb_we (1), wb_wa (5) and wb_wd (XLEN), input, meaning the writeback port, also driven to the register file.
REQ-012 SHALL have ports ex_valid (1), ex_pc (XLEN), ex_rs1_val (XLEN), ex_rs2_val (XLEN) and ex_imm (XLEN), output, meaning the ID/EX register contents.
REQ-013 SHALL have ports ex_rs1, ex_rs2 and ex_rd, output, 5, meaning registered source and destination indices used for EX forwarding.
REQ-014 SHALL have port ex_ctrl, output, CTRL_W, meaning the registered control bundle: alu_op[3:0], alu_src_imm, alu_src_pc, mem_rd, mem_wr, mem_size[2:0], reg_we, wb_sel[1:0], branch, jump, jalr.

Function
REQ-015 SHALL drive ra1 = if_instr[19:15] and ra2 = if_instr[24:20] combinationally, irrespective of opcode.
REQ-016 SHALL bypass WB: source value = wb_wd when wb_we, wb_wa != 0 and wb_wa == ra; otherwise rd1/rd2.
REQ-017 SHALL decode LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP; any other opcode SHALL decode to a NOP (ctrl all zero, ex_rd = 0).
REQ-018 SHALL force ex_rd = 0 and reg_we = 0 for STORE and BRANCH.
REQ-019 SHALL generate sign-extended I/S/B/U/J immediates with bit 0 of B and J = 0, and U = {instr[31:12], 12'b0}.
REQ-020 SHALL register all ex_* outputs with exactly 1-cycle latency from the IF/ID inputs.
REQ-021 SHALL detect load-use: ex_valid, ex_ctrl.mem_rd, ex_rd != 0, and ex_rd equals a source actually used by the ID instruction format (rs1: all formats except LUI/AUIPC/JAL; rs2: OP, STORE, BRANCH).
REQ-022 SHALL, on load-use with if_valid and no flush, assert id_stall combinationally and load a bubble into ID/EX (ex_valid = 0, ex_ctrl = 0, ex_rd = 0).
REQ-023 SHALL stall for exactly one cycle per load-use, with the held instruction issuing on the following cycle.
REQ-024 SHALL give flush priority over stall: id_stall = 0 and the next ID/EX is a bubble.
REQ-025 SHALL load a bubble when if_valid = 0.
REQ-026 SHALL keep id_stall deasserted whenever if_valid = 0.

Reset
REQ-027 SHALL, while rst is high at a clock edge, clear ex_valid, ex_ctrl, ex_rd, ex_rs1, ex_rs2, ex_pc, ex_imm, ex_rs1_val and ex_rs2_val to 0, and keep id_stall = 0.
REQ-028 SHALL have rst override flush and stall; the first instruction after reset deassertion SHALL decode normally.

Structure
REQ-029 SHALL take opcode constants, alu_op encodings, wb_sel encodings, CTRL_W and ctrl field offsets from shared package cpu_pkg, which the EX stage also uses.
REQ-030 SHALL implement immediate generation in the sub-module imm_gen (combinational, instr in, imm out).

Verification
REQ-031 SHALL cover: ADDI x5,x0,-1 -> next cycle ex_imm = 0xFFFFFFFF, alu_src_imm = 1, ex_rd = 5, reg_we = 1.
REQ-032 SHALL cover: ADD x3,x1,x2 with wb_we = 1, wb_wa = 1, wb_wd = 0x1234 and rd1 = 0 in the same cycle -> ex_rs1_val = 0x1234.
REQ-033 SHALL cover: LW x4 followed by ADD x6,x4,x7 -> id_stall = 1 for one cycle, one bubble, then the ADD issues with ex_rs1 = 4.
REQ-034 SHALL cover: LW x4 followed by LUI x4 -> no stall (rs1 is unused).
REQ-035 SHALL cover: load-use and flush in the same cycle -> id_stall = 0 and ex_valid = 0 next cycle.
REQ-036 SHALL cover: rst asserted mid-stream -> all ex_* outputs = 0 next cycle, and BEQ offset -4 after release -> ex_imm = 0xFFFFFFFC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcodes, ALU and writeback encodings,
// and the ID/EX control bundle layout used by both ID and EX.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // mem_size carries funct3 for loads, stores and branches;
  // for branches EX reads it as the compare condition.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] mem_size;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jump;
    logic       jalr;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam int CTRL_JALR    = 0;
  localparam int CTRL_JUMP    = 1;
  localparam int CTRL_BRANCH  = 2;
  localparam int CTRL_WB_SEL  = 3;
  localparam int CTRL_REG_WE  = 5;
  localparam int CTRL_MEMSIZE = 6;
  localparam int CTRL_MEM_WR  = 9;
  localparam int CTRL_MEM_RD  = 10;
  localparam int CTRL_SRC_PC  = 11;
  localparam int CTRL_SRC_IMM = 12;
  localparam int CTRL_ALU_OP  = 13;

  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// RV32I immediate generator (I/S/B/U/J, sign-extended to XLEN).
// Ports: instr (32-bit word) in, imm (XLEN) out; purely combinational.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] i32;
  logic        [31:0] w;

  assign w = instr;

  always_comb begin
    i32 = '0;
    unique case (1'b1)
      (w[6:0] == OP_LUI),
      (w[6:0] == OP_AUIPC):
        i32 = {w[31:12], 12'b0};
      (w[6:0] == OP_JAL):
        i32 = {{11{w[31]}}, w[31], w[19:12],
               w[20], w[30:21], 1'b0};
      (w[6:0] == OP_BRANCH):
        i32 = {{19{w[31]}}, w[31], w[7],
               w[30:25], w[11:8], 1'b0};
      (w[6:0] == OP_STORE):
        i32 = {{20{w[31]}}, w[31:25], w[11:7]};
      (w[6:0] == OP_JALR),
      (w[6:0] == OP_LOAD),
      (w[6:0] == OP_OPIMM):
        i32 = {{20{w[31]}}, w[31:20]};
      default:
        i32 = '0;
    endcase
  end

  assign imm = XLEN'(i32);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: register read with WB bypass, control decode,
// load-use stall, and the ID/EX pipeline register (ex_* outputs).
module id_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_pc,
  input  logic [31:0]       if_instr,
  input  logic              flush,
  output logic              id_stall,
  output logic [4:0]        ra1,
  output logic [4:0]        ra2,
  input  logic [XLEN-1:0]   rd1,
  input  logic [XLEN-1:0]   rd2,
  input  logic              wb_we,
  input  logic [4:0]        wb_wa,
  input  logic [XLEN-1:0]   wb_wd,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic [6:0]      op;
  logic [2:0]      f3;
  ctrl_t           c;
  ctrl_t           ex_c;
  logic [4:0]      rd;
  logic            use1;
  logic            use2;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] v1;
  logic [XLEN-1:0] v2;
  logic            lu;
  logic            bubble;

  assign op  = if_instr[6:0];
  assign f3  = if_instr[14:12];
  assign ra1 = if_instr[19:15];
  assign ra2 = if_instr[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm (
    .instr (if_instr),
    .imm   (imm)
  );

  assign v1 = (wb_we && wb_wa != '0 && wb_wa == ra1)
            ? wb_wd : rd1;
  assign v2 = (wb_we && wb_wa != '0 && wb_wa == ra2)
            ? wb_wd : rd2;

  always_comb begin
    c    = '0;
    rd   = if_instr[11:7];
    use1 = 1'b0;
    use2 = 1'b0;
    unique case (1'b1)
      (op == OP_LUI): begin
        c.alu_op      = ALU_PASSB;
        c.alu_src_imm = 1'b1;
        c.reg_we      = 1'b1;
      end
      (op == OP_AUIPC): begin
        c.alu_src_imm = 1'b1;
        c.alu_src_pc  = 1'b1;
        c.reg_we      = 1'b1;
      end
      (op == OP_JAL): begin
        c.alu_src_imm = 1'b1;
        c.alu_src_pc  = 1'b1;
        c.reg_we      = 1'b1;
        c.wb_sel      = WB_PC4;
        c.jump        = 1'b1;
      end
      (op == OP_JALR): begin
        c.alu_src_imm = 1'b1;
        c.reg_we      = 1'b1;
        c.wb_sel      = WB_PC4;
        c.jump        = 1'b1;
        c.jalr        = 1'b1;
        use1          = 1'b1;
      end
      (op == OP_BRANCH): begin
        c.alu_op   = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT)
                           : ALU_SUB;
        c.mem_size = f3;
        c.branch   = 1'b1;
        rd         = '0;
        use1       = 1'b1;
        use2       = 1'b1;
      end
      (op == OP_LOAD): begin
        c.alu_src_imm = 1'b1;
        c.mem_rd      = 1'b1;
        c.mem_size    = f3;
        c.reg_we      = 1'b1;
        c.wb_sel      = WB_MEM;
        use1          = 1'b1;
      end
      (op == OP_STORE): begin
        c.alu_src_imm = 1'b1;
        c.mem_wr      = 1'b1;
        c.mem_size    = f3;
        rd            = '0;
        use1          = 1'b1;
        use2          = 1'b1;
      end
      (op == OP_OPIMM): begin
        c.alu_op = alu_dec(f3, f3 == 3'b101 && if_instr[30]);
        c.alu_src_imm = 1'b1;
        c.reg_we      = 1'b1;
        use1          = 1'b1;
      end
      (op == OP_OP): begin
        c.alu_op = alu_dec(f3, if_instr[30]);
        c.reg_we = 1'b1;
        use1     = 1'b1;
        use2     = 1'b1;
      end
      default: rd = '0;
    endcase
  end

  assign lu = ex_valid && ex_c.mem_rd && ex_rd != '0
           && ((use1 && ex_rd == ra1) || (use2 && ex_rd == ra2));

  assign id_stall = if_valid && lu && !flush && !rst;
  assign bubble   = !if_valid || flush || lu;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_c       <= '0;
      ex_rd      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
    end else begin
      ex_valid   <= !bubble;
      ex_c       <= bubble ? '0 : c;
      ex_rd      <= bubble ? '0 : rd;
      ex_rs1     <= (bubble || !use1) ? '0 : ra1;
      ex_rs2     <= (bubble || !use2) ? '0 : ra2;
      ex_pc      <= if_pc;
      ex_imm     <= imm;
      ex_rs1_val <= v1;
      ex_rs2_val <= v2;
    end
  end

  assign ex_ctrl = ex_c;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage.
// One task per scenario, hand-computed expectations.
module tb_id_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              flush;
  logic              id_stall;
  logic [4:0]        ra1, ra2;
  logic [31:0]       rd1, rd2;
  logic              wb_we;
  logic [4:0]        wb_wa;
  logic [31:0]       wb_wd;
  logic              ex_valid;
  logic [31:0]       ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  ctrl_t             c;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] I_ADDI = 32'hFFF00293;
  localparam logic [31:0] I_ADD3 = 32'h002081B3;
  localparam logic [31:0] I_LW4  = 32'h0000A203;
  localparam logic [31:0] I_ADD6 = 32'h00720333;
  localparam logic [31:0] I_LUI4 = 32'h12345237;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_SW   = 32'h00722423;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_CUST = 32'h00000F8B;
  localparam logic [31:0] I_AUI  = 32'h80000117;

  always #5 clk = ~clk;

  assign c = ctrl_t'(ex_ctrl);

  id_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .flush      (flush),
    .id_stall   (id_stall),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .wb_we      (wb_we),
    .wb_wa      (wb_wa),
    .wb_wd      (wb_wd),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_rs1_val (ex_rs1_val),
    .ex_rs2_val (ex_rs2_val),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .ex_rs2     (ex_rs2),
    .ex_rd      (ex_rd),
    .ex_ctrl    (ex_ctrl)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0;
    flush = 1'b0; rd1 = '0; rd2 = '0;
    wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
    tick(); tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0) begin
      errors++;
      $display("FAIL reset_ex got v=%b c=%h rd=%0d req 0", ex_valid, ex_ctrl, ex_rd);
    end
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b req 0", id_stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    drive(I_ADDI, 32'h100);
    #1;
    checks++;
    if (ra1 !== 5'd0 || ra2 !== 5'd31) begin
      errors++;
      $display("FAIL addi_ra got %0d/%0d req 0/31", ra1, ra2);
    end
    tick();
    checks++;
    if (ex_imm !== 32'hFFFFFFFF || ex_rd !== 5'd5 || ex_pc !== 32'h100) begin
      errors++;
      $display("FAIL addi_imm got imm=%h rd=%0d pc=%h req ffffffff/5/100", ex_imm, ex_rd, ex_pc);
    end
    checks++;
    if (c.alu_src_imm !== 1'b1 || c.reg_we !== 1'b1 || c.alu_op !== ALU_ADD || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL addi_ctrl got %h req src_imm,reg_we,ADD", ex_ctrl);
    end
  endtask

  task automatic test_bypass();
    drive(I_ADD3, 32'h104);
    rd1 = 32'h0; rd2 = 32'h55;
    wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'h1234;
    tick();
    checks++;
    if (ex_rs1_val !== 32'h1234 || ex_rs2_val !== 32'h55) begin
      errors++;
      $display("FAIL bypass_rs1 got %h/%h req 1234/55", ex_rs1_val, ex_rs2_val);
    end
    checks++;
    if (ex_rs1 !== 5'd1 || ex_rs2 !== 5'd2 || ex_rd !== 5'd3) begin
      errors++;
      $display("FAIL add_idx got %0d/%0d/%0d req 1/2/3", ex_rs1, ex_rs2, ex_rd);
    end
    drive(32'h002001B3, 32'h108);
    wb_wa = 5'd0; wb_wd = 32'hDEAD;
    tick();
    checks++;
    if (ex_rs1_val !== 32'h0) begin
      errors++;
      $display("FAIL bypass_x0 got %h req 0", ex_rs1_val);
    end
    wb_we = 1'b0; rd2 = '0;
  endtask

  task automatic test_load_use();
    drive(I_LW4, 32'h200);
    tick();
    checks++;
    if (c.mem_rd !== 1'b1 || c.wb_sel !== WB_MEM || ex_rd !== 5'd4) begin
      errors++;
      $display("FAIL lw_ctrl got %h rd=%0d req mem_rd/4", ex_ctrl, ex_rd);
    end
    drive(I_ADD6, 32'h204);
    #1;
    checks++;
    if (id_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b req 1", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_bubble got v=%b c=%h rd=%0d st=%b req 0", ex_valid, ex_ctrl, ex_rd, id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd4 || ex_rs2 !== 5'd7 || ex_rd !== 5'd6) begin
      errors++;
      $display("FAIL lu_issue got v=%b rs1=%0d rs2=%0d rd=%0d req 1/4/7/6", ex_valid, ex_rs1, ex_rs2, ex_rd);
    end
  endtask

  task automatic test_lui_no_stall();
    drive(I_LW4, 32'h300);
    tick();
    drive(I_LUI4, 32'h304);
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL lui_stall got %b req 0", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || ex_imm !== 32'h12345000 || c.alu_op !== ALU_PASSB) begin
      errors++;
      $display("FAIL lui_issue got v=%b rd=%0d imm=%h req 1/4/12345000", ex_valid, ex_rd, ex_imm);
    end
  endtask

  task automatic test_flush();
    drive(I_LW4, 32'h400);
    tick();
    drive(I_ADD6, 32'h404);
    flush = 1'b1;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %b req 0", id_stall);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0) begin
      errors++;
      $display("FAIL flush_bubble got v=%b c=%h rd=%0d req 0", ex_valid, ex_ctrl, ex_rd);
    end
  endtask

  task automatic test_invalid();
    drive(I_LW4, 32'h500);
    tick();
    drive(I_ADD6, 32'h504);
    if_valid = 1'b0;
    #1;
    checks++;
    if (id_stall !== 1'b0) begin
      errors++;
      $display("FAIL inv_stall got %b req 0", id_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0) begin
      errors++;
      $display("FAIL inv_bubble got v=%b c=%h rd=%0d req 0", ex_valid, ex_ctrl, ex_rd);
    end
  endtask

  task automatic test_formats();
    drive(I_SW, 32'h600);
    tick();
    checks++;
    if (ex_imm !== 32'h8 || ex_rd !== '0 || c.reg_we !== 1'b0 || c.mem_wr !== 1'b1 || c.mem_size !== 3'b010) begin
      errors++;
      $display("FAIL store got imm=%h rd=%0d c=%h req 8/0/mem_wr", ex_imm, ex_rd, ex_ctrl);
    end
    drive(I_JAL, 32'h604);
    tick();
    checks++;
    if (ex_imm !== 32'h10 || ex_rd !== 5'd1 || c.jump !== 1'b1 || c.wb_sel !== WB_PC4 || ex_rs1 !== '0) begin
      errors++;
      $display("FAIL jal got imm=%h rd=%0d c=%h req 10/1/jump", ex_imm, ex_rd, ex_ctrl);
    end
    drive(I_AUI, 32'h608);
    tick();
    checks++;
    if (ex_imm !== 32'h80000000 || c.alu_src_pc !== 1'b1 || ex_rd !== 5'd2) begin
      errors++;
      $display("FAIL auipc got imm=%h c=%h rd=%0d req 80000000/src_pc/2", ex_imm, ex_ctrl, ex_rd);
    end
    drive(I_CUST, 32'h60C);
    tick();
    checks++;
    if (ex_ctrl !== '0 || ex_rd !== '0) begin
      errors++;
      $display("FAIL nop got c=%h rd=%0d req 0/0", ex_ctrl, ex_rd);
    end
  endtask

  task automatic test_reset_mid();
    drive(I_ADDI, 32'h700);
    tick();
    rst = 1'b1;
    drive(I_ADD6, 32'h704);
    flush = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || ex_rs1 !== '0 || ex_rs2 !== '0 ||
        ex_pc !== '0 || ex_imm !== '0 || ex_rs1_val !== '0 || ex_rs2_val !== '0) begin
      errors++;
      $display("FAIL rst_mid got v=%b c=%h rd=%0d pc=%h imm=%h req all 0", ex_valid, ex_ctrl, ex_rd, ex_pc, ex_imm);
    end
    rst = 1'b0; flush = 1'b0;
    drive(I_BEQ, 32'h800);
    tick();
    checks++;
    if (ex_imm !== 32'hFFFFFFFC || ex_valid !== 1'b1 || c.branch !== 1'b1 || ex_rd !== '0 || c.reg_we !== 1'b0) begin
      errors++;
      $display("FAIL beq got imm=%h v=%b c=%h rd=%0d req fffffffc/1/branch/0", ex_imm, ex_valid, ex_ctrl, ex_rd);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_lui_no_stall();
    test_flush();
    test_invalid();
    test_formats();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
